fetch: RTL and testbench

//  Instruction-fetch stage of the RV32I_Zicsr pipeline, directly upstream of decode.

---
 rtl/fetch.sv | 138 +++++++++++++
 tb/tb_fetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request,
// and presents a registered instruction to decode with a 1-entry skid buffer.
module fetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_drop;
    logic            w_drop_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_fly_pc;
    logic            r_skid_valid;
    logic [XLEN-1:0] r_skid_inst;
    logic [XLEN-1:0] r_skid_pc;
    logic            w_accept;
    logic            w_resp;
    logic            w_out_free;

    assign o_imem_addr = r_pc;

    always_comb begin
        o_imem_req  = i_rst_n && (r_state == S_IDLE)
                      && !i_flush && !r_skid_valid;
        w_accept    = o_imem_req && i_imem_ready;
        w_resp      = (r_state == S_WAIT) && i_imem_rvalid
                      && !r_drop && !i_flush;
        w_out_free  = !or_valid || !i_stall;
        w_state_nxt = r_state;
        w_drop_nxt  = r_drop;
        w_pc_nxt    = r_pc;
        if (i_flush) begin
            w_pc_nxt = {i_redirect_pc[XLEN-1:2], 2'b00};
            // An unanswered request stays outstanding; its data is dropped later.
            if ((r_state == S_WAIT) && !i_imem_rvalid) begin
                w_drop_nxt = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
                w_drop_nxt  = 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_pc_nxt    = r_pc + XLEN'(4);
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        w_state_nxt = S_IDLE;
                        w_drop_nxt  = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fly_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_inst  <= NOP_INST;
            r_skid_pc    <= '0;
            or_valid     <= 1'b0;
            or_inst      <= NOP_INST;
            or_pc        <= '0;
        end else begin
            if (w_accept) begin
                r_fly_pc <= r_pc;
            end
            if (i_flush) begin
                or_valid     <= 1'b0;
                or_inst      <= NOP_INST;
                r_skid_valid <= 1'b0;
            end else if (w_out_free) begin
                if (r_skid_valid) begin
                    or_valid     <= 1'b1;
                    or_inst      <= r_skid_inst;
                    or_pc        <= r_skid_pc;
                    r_skid_valid <= 1'b0;
                end else if (w_resp) begin
                    or_valid <= 1'b1;
                    or_inst  <= i_imem_rdata;
                    or_pc    <= r_fly_pc;
                end else begin
                    or_valid <= 1'b0;
                    or_inst  <= NOP_INST;
                end
            end else if (w_resp) begin
                r_skid_valid <= 1'b1;
                r_skid_inst  <= i_imem_rdata;
                r_skid_pc    <= r_fly_pc;
            end
        end
    end

    // A response is only legal while a request is outstanding.
    a_no_stray_rvalid: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (r_state == S_IDLE) |-> !i_imem_rvalid
    );

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: vector table for streaming/stall/skid,
// hand-written sequences for flush, redirect wrap and mid-transaction reset.
module tb_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redir = '0;
    logic        req;
    logic [31:0] addr;
    logic        ready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    fetch dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_stall      (stall),
        .i_flush      (flush),
        .i_redirect_pc(redir),
        .o_imem_req   (req),
        .o_imem_addr  (addr),
        .i_imem_ready (ready),
        .i_imem_rvalid(rvalid),
        .i_imem_rdata (rdata),
        .or_inst      (inst),
        .or_pc        (pc),
        .or_valid     (valid)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] redir;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t v(
        input logic st, input logic fl, input logic [31:0] rd_pc,
        input logic rdy, input logic rv, input logic [31:0] dat,
        input logic er, input logic [31:0] ea,
        input logic ev, input logic [31:0] ei, input logic [31:0] ep
    );
        vec_t r;
        r.stall = st;  r.flush = fl;   r.redir = rd_pc;
        r.ready = rdy; r.rvalid = rv;  r.rdata = dat;
        r.e_req = er;  r.e_addr = ea;
        r.e_valid = ev; r.e_inst = ei; r.e_pc = ep;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Drive one cycle: check combinational request before the edge,
    // registered outputs just after it.
    task automatic apply(input string tag, input vec_t x);
        stall  = x.stall;
        flush  = x.flush;
        redir  = x.redir;
        ready  = x.ready;
        rvalid = x.rvalid;
        rdata  = x.rdata;
        #1;
        chk({tag, " req"},  32'(req),  32'(x.e_req));
        chk({tag, " addr"}, addr, x.e_addr);
        @(posedge clk);
        #1;
        chk({tag, " valid"}, 32'(valid), 32'(x.e_valid));
        chk({tag, " inst"},  inst, x.e_inst);
        chk({tag, " pc"},    pc,   x.e_pc);
    endtask

    localparam logic [31:0] NOP = 32'h13;

    vec_t tbl [14];

    initial begin
        tbl[0]  = v(0,0,0,1,0,0,            1,32'h0,  0,NOP,0);
        tbl[1]  = v(0,0,0,1,1,32'hA000,     0,32'h4,  1,32'hA000,32'h0);
        tbl[2]  = v(0,0,0,1,0,0,            1,32'h4,  0,NOP,32'h0);
        tbl[3]  = v(0,0,0,1,1,32'hA004,     0,32'h8,  1,32'hA004,32'h4);
        tbl[4]  = v(1,0,0,1,0,0,            1,32'h8,  1,32'hA004,32'h4);
        tbl[5]  = v(1,0,0,1,1,32'hA008,     0,32'hC,  1,32'hA004,32'h4);
        tbl[6]  = v(1,0,0,1,0,0,            0,32'hC,  1,32'hA004,32'h4);
        tbl[7]  = v(0,0,0,1,0,0,            0,32'hC,  1,32'hA008,32'h8);
        tbl[8]  = v(0,0,0,1,0,0,            1,32'hC,  0,NOP,32'h8);
        tbl[9]  = v(0,0,0,1,1,32'hA00C,     0,32'h10, 1,32'hA00C,32'hC);
        tbl[10] = v(0,0,0,0,0,0,            1,32'h10, 0,NOP,32'hC);
        tbl[11] = v(0,0,0,1,0,0,            1,32'h10, 0,NOP,32'hC);
        tbl[12] = v(0,0,0,1,0,0,            0,32'h14, 0,NOP,32'hC);
        tbl[13] = v(0,0,0,1,1,32'hB010,     0,32'h14, 1,32'hB010,32'h10);

        repeat (2) @(posedge clk);
        #1;
        chk("rst req",   32'(req),   32'd0);
        chk("rst valid", 32'(valid), 32'd0);
        chk("rst inst",  inst, NOP);
        chk("rst pc",    pc,   32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst first req",  32'(req), 32'd1);
        chk("rst first addr", addr, 32'h0);

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // Flush in WAIT: stale response dropped, fetch resumes at 0x100.
        apply("fw0", v(0,0,0,1,0,0,          1,32'h14,  0,NOP,32'h10));
        apply("fw1", v(0,1,32'h100,0,0,0,    0,32'h18,  0,NOP,32'h10));
        apply("fw2", v(0,0,0,0,1,32'hDEAD,   0,32'h100, 0,NOP,32'h10));
        apply("fw3", v(0,0,0,1,0,0,          1,32'h100, 0,NOP,32'h10));
        apply("fw4", v(0,0,0,1,1,32'hC100,   0,32'h104, 1,32'hC100,32'h100));

        // Two flushes while the same request is outstanding: newest wins.
        apply("dd0", v(0,0,0,1,0,0,          1,32'h104, 0,NOP,32'h100));
        apply("dd1", v(0,1,32'h200,0,0,0,    0,32'h108, 0,NOP,32'h100));
        apply("dd2", v(0,1,32'h300,0,0,0,    0,32'h200, 0,NOP,32'h100));
        apply("dd3", v(0,0,0,0,1,32'hBAD0,   0,32'h300, 0,NOP,32'h100));
        apply("dd4", v(0,0,0,1,0,0,          1,32'h300, 0,NOP,32'h100));
        apply("dd5", v(0,0,0,1,1,32'hD300,   0,32'h304, 1,32'hD300,32'h300));

        // Flush + stall + rvalid in the same cycle.
        apply("fs0", v(1,0,0,1,0,0,          1,32'h304, 1,32'hD300,32'h300));
        apply("fs1", v(1,1,32'h400,1,1,32'hEEEE,
                                             0,32'h308, 0,NOP,32'h300));
        apply("fs2", v(1,0,0,1,0,0,          1,32'h400, 0,NOP,32'h300));
        apply("fs3", v(0,0,0,1,1,32'hE400,   0,32'h404, 1,32'hE400,32'h400));

        // Flush in IDLE suppresses the request; redirect wraps and aligns.
        apply("wr0", v(0,1,32'hFFFF_FFFC,1,0,0,
                                             0,32'h404, 0,NOP,32'h400));
        apply("wr1", v(0,0,0,1,0,0,          1,32'hFFFF_FFFC, 0,NOP,32'h400));
        apply("wr2", v(0,0,0,1,1,32'hF0F0,   0,32'h0,
                                             1,32'hF0F0,32'hFFFF_FFFC));
        apply("wr3", v(0,0,0,0,0,0,          1,32'h0,   0,NOP,32'hFFFF_FFFC));
        apply("wr4", v(0,1,32'h103,0,0,0,    0,32'h0,   0,NOP,32'hFFFF_FFFC));
        apply("wr5", v(0,0,0,1,0,0,          1,32'h100, 0,NOP,32'hFFFF_FFFC));

        // Reset while a request is outstanding.
        stall = 1'b0; flush = 1'b0; ready = 1'b0; rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr req", 32'(req), 32'd0);
        @(posedge clk);
        #1;
        chk("mr valid", 32'(valid), 32'd0);
        chk("mr inst",  inst, NOP);
        chk("mr pc",    pc,   32'h0);
        rst_n = 1'b1;
        #1;
        chk("mr req after", 32'(req), 32'd1);
        chk("mr addr after", addr, 32'h0);
        apply("mr0", v(0,0,0,1,0,0,          1,32'h0,  0,NOP,32'h0));
        apply("mr1", v(0,0,0,1,1,32'h1234,   0,32'h4,  1,32'h1234,32'h0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
